// File: rtl/reaction_timer_bcd_pkg.sv
// reaction_pkg: shared types and constants for the reaction-time benchmark.
//   state_e          - trial FSM states
//   LFSR_TAPS        - Galois mask for x^16+x^14+x^13+x^11 (right-shifting form)
//   BCD_MAX          - saturation value of the 4-digit BCD count
//   FALSE_START_CODE - pattern shown on the decoders after a premature click
//   lfsr_next()      - one step of the free-running random generator
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RAND,
        S_GO,
        S_RESULT,
        S_FALSE_START
    } state_e;

    localparam logic [15:0] LFSR_TAPS        = 16'hB400;
    localparam logic [15:0] BCD_MAX          = 16'h9999;
    localparam logic [15:0] FALSE_START_CODE = 16'hFFFF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_counter4.sv
// bcd_counter4: cascaded 4-digit decimal counter that saturates at 9999.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset (value -> 0000)
//   clr_i    - synchronous clear, wins over inc_i
//   inc_i    - add one to the units digit (ignored once saturated)
//   value_o  - {d3,d2,d1,d0}, d0 is the units digit
//   sat_o    - high while the value is 9999
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] value_o,
    output logic        sat_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        carry;

    assign sat_o   = (cnt_q == BCD_MAX);
    assign value_o = cnt_q;

    // Ripple the increment through the digits; a digit at 9 wraps and carries.
    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (cnt_q[i*4 +: 4] == 4'd9) begin
                        cnt_d[i*4 +: 4] = 4'd0;
                    end else begin
                        cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reaction_timer_bcd.sv
// reaction_timer_bcd: reaction-time trial controller feeding four BCD digits
// to the HEX0..HEX3 decoders.
//   CLOCK_50  - system clock, rising edge
//   resetn    - asynchronous active-low reset
//   start     - one-cycle pulse, begin/restart a trial
//   click     - one-cycle pulse, user response
//   stimulus  - GO indication
//   busy      - trial in progress (WAIT_RAND or GO)
//   too_soon  - false start
//   overflow  - result saturated at 9999
//   bcd       - {d3,d2,d1,d0} result digits, FFFF after a false start
//   best_bcd  - best valid result when REACTION_BEST_SCORE_EN is defined, else 0
// Optional feature macro: REACTION_BEST_SCORE_EN
module reaction_timer_bcd
    import reaction_pkg::*;
#(
    parameter int          CLK_HZ       = 50000000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        click,
    output logic        stimulus,
    output logic        busy,
    output logic        too_soon,
    output logic        overflow,
    output logic [15:0] bcd,
    output logic [15:0] best_bcd
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(MIN_DELAY_MS + 2048 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e        state_q;
    logic [15:0]   lfsr_q;
    logic [TW-1:0] tick_q;
    logic [DW-1:0] delay_q;
    logic          stim_q, busy_q, too_soon_q, ovf_q;

    logic          ms_tick;
    logic          cnt_clr, cnt_inc, cnt_sat;
    logic [15:0]   cnt_value;
    logic [DW-1:0] delay_load;

    assign ms_tick    = (tick_q == TICK_LAST);
    assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q[10:0]);

    // A start is accepted only where the FSM leaves for WAIT_RAND.
    assign cnt_clr = start && (state_q == S_IDLE || state_q == S_RESULT ||
                               state_q == S_FALSE_START);
    // A tick in the click cycle is dropped so the result freezes as shown.
    assign cnt_inc = (state_q == S_GO) && ms_tick && !click;

    bcd_counter4 u_count (
        .clk_i   (CLOCK_50),
        .rst_ni  (resetn),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .value_o (cnt_value),
        .sat_o   (cnt_sat)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_next(lfsr_q);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            delay_q    <= '0;
            stim_q     <= 1'b0;
            busy_q     <= 1'b0;
            too_soon_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            tick_q <= ms_tick ? '0 : tick_q + 1'b1;
            case (state_q)
                S_IDLE, S_RESULT, S_FALSE_START: begin
                    if (start) begin
                        state_q    <= S_WAIT_RAND;
                        tick_q     <= '0;
                        delay_q    <= delay_load;
                        stim_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        too_soon_q <= 1'b0;
                        ovf_q      <= 1'b0;
                    end
                end
                S_WAIT_RAND: begin
                    if (click) begin
                        state_q    <= S_FALSE_START;
                        tick_q     <= '0;
                        busy_q     <= 1'b0;
                        too_soon_q <= 1'b1;
                    end else if (ms_tick) begin
                        if (delay_q == '0) begin
                            state_q <= S_GO;
                            tick_q  <= '0;
                            stim_q  <= 1'b1;
                        end else begin
                            delay_q <= delay_q - 1'b1;
                        end
                    end
                end
                S_GO: begin
                    if (click || (ms_tick && cnt_sat)) begin
                        state_q <= S_RESULT;
                        tick_q  <= '0;
                        stim_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ovf_q   <= !click;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stimulus = stim_q;
    assign busy     = busy_q;
    assign too_soon = too_soon_q;
    assign overflow = ovf_q;
    assign bcd      = too_soon_q ? FALSE_START_CODE : cnt_value;

`ifdef REACTION_BEST_SCORE_EN
    logic [15:0] best_q;

    // Packed BCD orders the same as the decimal value, so a plain compare works.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            best_q <= BCD_MAX;
        else if (state_q == S_GO && click && cnt_value < best_q)
            best_q <= cnt_value;
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = '0;
`endif

endmodule

// File: tb/tb_reaction_timer_bcd.sv
module tb_reaction_timer_bcd;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b1;
    logic        start    = 1'b0;
    logic        click    = 1'b0;
    logic        stimulus, busy, too_soon, overflow;
    logic [15:0] bcd, best_bcd;

    int tests = 0;
    int fails = 0;

`ifdef REACTION_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    reaction_timer_bcd #(
        .CLK_HZ       (1000),
        .MIN_DELAY_MS (5),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .click    (click),
        .stimulus (stimulus),
        .busy     (busy),
        .too_soon (too_soon),
        .overflow (overflow),
        .bcd      (bcd),
        .best_bcd (best_bcd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [15:0] best_exp(input logic [15:0] v);
        return BEST_EN ? v : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_click();
        click = 1'b1;
        step();
        click = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (stimulus !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        check(tag, {15'd0, stimulus}, 16'd1);
    endtask

    initial begin
        #2 resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_bcd", bcd, 16'h0000);
        check("rst_stim", {15'd0, stimulus}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_too_soon", {15'd0, too_soon}, 16'd0);
        check("rst_ovf", {15'd0, overflow}, 16'd0);
        check("rst_best", best_bcd, best_exp(16'h9999));
        @(negedge CLOCK_50);
        resetn = 1'b1;
        step();

        // start and click together in IDLE: start wins
        start = 1'b1;
        click = 1'b1;
        step();
        start = 1'b0;
        click = 1'b0;
        check("sc_busy", {15'd0, busy}, 16'd1);
        check("sc_too_soon", {15'd0, too_soon}, 16'd0);
        wait_go("go_137");
        check("go_bcd0", bcd, 16'h0000);
        repeat (137) step();
        pulse_click();
        check("r137_bcd", bcd, 16'h0137);
        check("r137_stim", {15'd0, stimulus}, 16'd0);
        check("r137_busy", {15'd0, busy}, 16'd0);
        check("r137_ovf", {15'd0, overflow}, 16'd0);

        // click in RESULT is ignored
        pulse_click();
        step();
        check("res_click_ign", bcd, 16'h0137);

        // false start
        pulse_start();
        check("fs_busy_wait", {15'd0, busy}, 16'd1);
        check("fs_bcd_clr", bcd, 16'h0000);
        step();
        pulse_click();
        check("fs_too_soon", {15'd0, too_soon}, 16'd1);
        check("fs_bcd", bcd, 16'hFFFF);
        check("fs_stim", {15'd0, stimulus}, 16'd0);
        check("fs_busy", {15'd0, busy}, 16'd0);
        repeat (3) step();
        check("fs_hold", bcd, 16'hFFFF);
        pulse_start();
        check("fs_clr_too_soon", {15'd0, too_soon}, 16'd0);
        check("fs_clr_bcd", bcd, 16'h0000);
        check("fs_restart_busy", {15'd0, busy}, 16'd1);

        // click coincident with a tick at 0199
        wait_go("go_199");
        repeat (199) step();
        pulse_click();
        check("r199_bcd", bcd, 16'h0199);
        check("r199_best", best_bcd, best_exp(16'h0137));

        // asynchronous reset mid-GO
        pulse_start();
        wait_go("go_rst");
        repeat (42) step();
        check("pre_rst_bcd", bcd, 16'h0042);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_bcd", bcd, 16'h0000);
        check("mid_rst_stim", {15'd0, stimulus}, 16'd0);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_best", best_bcd, best_exp(16'h9999));
        @(negedge CLOCK_50);
        resetn = 1'b1;
        start  = 1'b1;
        step();
        start = 1'b0;
        check("seed_busy", {15'd0, busy}, 16'd1);
        // seed 0xACE1 -> low 11 bits 0x4E1 = 1249, delay 1254, GO after 1255 ticks
        repeat (1254) step();
        check("seed_pre_go", {15'd0, stimulus}, 16'd0);
        step();
        check("seed_go", {15'd0, stimulus}, 16'd1);

        // best-score sequence: 0250, 0180, 0300, overflow
        repeat (250) step();
        pulse_click();
        check("r250_bcd", bcd, 16'h0250);
        step();
        check("r250_best", best_bcd, best_exp(16'h0250));

        pulse_start();
        wait_go("go_180");
        repeat (180) step();
        pulse_click();
        check("r180_bcd", bcd, 16'h0180);
        step();
        check("r180_best", best_bcd, best_exp(16'h0180));

        // start during GO is ignored; the pulse cycle still counts one tick
        pulse_start();
        wait_go("go_300");
        repeat (100) step();
        pulse_start();
        repeat (199) step();
        pulse_click();
        check("r300_bcd", bcd, 16'h0300);
        check("r300_too_soon", {15'd0, too_soon}, 16'd0);
        step();
        check("r300_best", best_bcd, best_exp(16'h0180));

        // carries and saturation
        pulse_start();
        wait_go("go_sat");
        repeat (9) step();
        check("c0009", bcd, 16'h0009);
        step();
        check("c0010", bcd, 16'h0010);
        repeat (989) step();
        check("c0999", bcd, 16'h0999);
        step();
        check("c1000", bcd, 16'h1000);
        repeat (8999) step();
        check("c9999", bcd, 16'h9999);
        check("c9999_ovf", {15'd0, overflow}, 16'd0);
        check("c9999_busy", {15'd0, busy}, 16'd1);
        step();
        check("sat_bcd", bcd, 16'h9999);
        check("sat_ovf", {15'd0, overflow}, 16'd1);
        check("sat_busy", {15'd0, busy}, 16'd0);
        check("sat_stim", {15'd0, stimulus}, 16'd0);
        repeat (5) step();
        check("sat_hold", bcd, 16'h9999);
        check("sat_best", best_bcd, best_exp(16'h0180));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
